// File: rtl/cp_iter_muldiv.sv
// rtl/cp_iter_muldiv.sv - iterative 32-cycle shift-add multiply / restoring divide coprocessor
// Optional remainder output port cp_rem is enabled by defining CP_REM_EN.
module cp_iter_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cp_s,
    input  logic            cp_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            cp_done,
    output logic [XLEN-1:0] cp_result,
    output logic            busy
`ifdef CP_REM_EN
    ,
    output logic [XLEN-1:0] cp_rem
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   shreg;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   rem;
    logic              op;
    logic [5:0]        cnt;

    logic              start;
    logic              finish;
    logic              div0;
    logic [2*XLEN-1:0] mul_sum;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic              qbit;
    logic [XLEN-1:0]   rem_next;

    assign div0     = op && (opb == '0);
    assign mul_sum  = acc + (shreg[0] ? mcand : '0);
    // Restoring step: shift next dividend bit into the remainder, keep the difference if no borrow.
    assign shifted  = {rem, shreg[XLEN-1]};
    assign diff     = shifted - {1'b0, opb};
    assign qbit     = ~diff[XLEN];
    assign rem_next = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign busy     = ~cp_done;

    always_comb begin
        next_state = state;
        start      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (cp_s) begin
                    start      = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (div0 || cnt == 6'(XLEN - 1)) begin
                    finish     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                start      = cp_s;
                next_state = cp_s ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cp_done <= 1'b1;
        end else begin
            state   <= next_state;
            cp_done <= (next_state != RUN);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            mcand     <= '0;
            shreg     <= '0;
            opb       <= '0;
            rem       <= '0;
            op        <= 1'b0;
            cnt       <= '0;
            cp_result <= '0;
`ifdef CP_REM_EN
            cp_rem    <= '0;
`endif
        end else if (start) begin
            acc   <= '0;
            mcand <= {{XLEN{1'b0}}, a};
            shreg <= cp_op ? a : b;
            opb   <= b;
            rem   <= '0;
            op    <= cp_op;
            cnt   <= '0;
        end else if (state == RUN) begin
            if (finish) begin
                if (op) begin
                    cp_result <= div0 ? '1 : {shreg[XLEN-2:0], qbit};
`ifdef CP_REM_EN
                    cp_rem    <= div0 ? shreg : rem_next;
`endif
                end else begin
                    cp_result <= mul_sum[XLEN-1:0];
                end
            end
            if (!div0) begin
                if (op) begin
                    rem   <= rem_next;
                    shreg <= {shreg[XLEN-2:0], qbit};
                end else begin
                    acc   <= mul_sum;
                    mcand <= mcand << 1;
                    shreg <= shreg >> 1;
                end
                if (cnt != 6'(XLEN - 1)) begin
                    cnt <= cnt + 6'd1;
                end
            end
        end
    end

endmodule

// File: doc/cp_iter_muldiv.md
CP_ITER_MULDIV -- requirements
Module: cp_iter_muldiv

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, operand and result width; only 32 needs to be supported and verified.
REQ-002 The port clk SHALL be an input of width 1 and is the single clock; all state changes on its rising edge.
REQ-003 The port reset SHALL be an input of width 1, asynchronous and active-low.
REQ-004 The port cp_s SHALL be an input of width 1 and is the start request.
REQ-005 The port cp_op SHALL be an input of width 1 and selects the operation: 0 = unsigned multiply, low word; 1 = unsigned divide, quotient.
REQ-006 The port a SHALL be an input of width XLEN and carries operand A (multiplicand or dividend), taken from register rs1.
REQ-007 The port b SHALL be an input of width XLEN and carries operand B (multiplier or divisor), taken from register rs2.
REQ-008 The port cp_done SHALL be an output of width 1; 0 means an operation is in progress and the processor stalls.
REQ-009 The port cp_result SHALL be an output of width XLEN and carries the result of the last completed operation.
REQ-010 The port busy SHALL be an output of width 1 and SHALL always equal the inverse of cp_done.

Function
REQ-011 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, a rising clk edge with cp_s=1 SHALL:
- latch a, b and cp_op;
- clear the 6-bit iteration counter;
- enter RUN.
REQ-013 In RUN, cp_s SHALL be ignored, and operand input changes SHALL have no effect.
REQ-014 Multiply SHALL use shift-add, one multiplier bit per cycle:
- 64-bit accumulator;
- cp_result = accumulator[31:0] on completion;
- overflow above bit 31 is discarded.
REQ-015 Divide SHALL be restoring, one quotient bit per cycle, with a 33-bit partial remainder; cp_result = quotient on completion.
REQ-016 Latency SHALL be exactly 32 cycles in RUN: with start sampled at edge N, the counter reaches 31 at edge N+32, and at that edge the result is written, cp_done=1 and the state is DONE.
REQ-017 Divide by zero (latched b==0) SHALL complete at edge N+1 with cp_result = 0xFFFFFFFF and no iteration.
REQ-018 cp_done SHALL be 1 in IDLE and DONE and 0 only in RUN, and SHALL be a registered output.
REQ-019 cp_result SHALL hold its value in IDLE, RUN and DONE until the next completion overwrites it; it is never partially updated.
REQ-020 The DONE state SHALL return to IDLE after one cycle when cp_s=0.
REQ-021 A start with cp_s=1 in the same cycle as the DONE entry edge SHALL not exist; a start in the DONE state SHALL be accepted per REQ-012 (back-to-back operation).
REQ-022 The iteration counter SHALL NOT wrap; it SHALL be cleared on every start.

Reset
REQ-023 reset=0 SHALL asynchronously force the following, including mid-operation:
- state IDLE;
- cp_done=1 and busy=0;
- cp_result=0;
- counter=0;
- accumulator and remainder registers cleared.
REQ-024 After reset is released, the first cp_s edge SHALL start a fresh operation with no residue of the aborted one.

Configuration
REQ-025 When the macro CP_REM_EN is defined, the block SHALL add the output port cp_rem (output, XLEN bits) carrying the divide remainder, with these rules:
- updated only on divide completion;
- reset to 0;
- equal to the dividend on divide by zero;
- unchanged by multiply.
REQ-026 When CP_REM_EN is undefined, the cp_rem port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 Multiply: a=7, b=6, cp_op=0, cp_s for one cycle -> cp_done=0 for 32 cycles, then cp_done=1 and cp_result=42.
REQ-028 Multiply overflow: a=0x80000001, b=4 -> cp_result=0x00000004 after 32 cycles.
REQ-029 Divide: a=100, b=7, cp_op=1 -> cp_result=14 after 32 cycles; with CP_REM_EN, cp_rem=2.
REQ-030 Divide by zero: a=5, b=0, cp_op=1 -> cp_done returns to 1 one cycle after start with cp_result=0xFFFFFFFF; with CP_REM_EN, cp_rem=5.
REQ-031 Reset mid-operation: start a multiply with a=3, b=3, then assert reset=0 at RUN cycle 10 -> immediately cp_done=1 and cp_result=0; after release, a new start with a=2, b=5 yields 10.
REQ-032 Start ignored while busy: start a=9, b=9, cp_op=0, then pulse cp_s with a=1, b=1 at RUN cycle 5 -> single completion at 32 cycles with cp_result=81.
